// File: rtl/user_port_endpoint.sv
// User-side endpoint of one leaf-interface port pair: RX and TX FWFT FIFOs on clk_user.
// Optional per-direction word counters are built when USER_PORT_CNT_EN is defined.

module user_port_fifo #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             push,
    output logic             pop
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic [ADDR_BITS:0]   count_nxt;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (count != '0);
    // Gate the head so stale storage never shows once the FIFO is empty.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            in_ready <= (count_nxt < DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

module user_port_endpoint #(
    parameter int PAYLOAD_BITS   = 32,
    parameter int FIFO_ADDR_BITS = 4
) (
    input  logic                    clk_user,
    input  logic                    reset,
`ifdef USER_PORT_CNT_EN
    output logic [31:0]             rx_word_count,
    output logic [31:0]             tx_word_count,
`endif
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
    input  logic                    vld_interface2user,
    output logic                    ack_user2interface,
    output logic [PAYLOAD_BITS-1:0] rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    input  logic [PAYLOAD_BITS-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic                    vld_user2interface,
    input  logic                    ack_interface2user
);

    logic rx_push;
    logic rx_pop;
    logic tx_push;
    logic tx_pop;

    user_port_fifo #(
        .WIDTH     (PAYLOAD_BITS),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_rx_fifo (
        .clk       (clk_user),
        .reset     (reset),
        .in_data   (dout_leaf_interface2user),
        .in_valid  (vld_interface2user),
        .in_ready  (ack_user2interface),
        .out_data  (rx_data),
        .out_valid (rx_valid),
        .out_ready (rx_ready),
        .push      (rx_push),
        .pop       (rx_pop)
    );

    user_port_fifo #(
        .WIDTH     (PAYLOAD_BITS),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_tx_fifo (
        .clk       (clk_user),
        .reset     (reset),
        .in_data   (tx_data),
        .in_valid  (tx_valid),
        .in_ready  (tx_ready),
        .out_data  (din_leaf_user2interface),
        .out_valid (vld_user2interface),
        .out_ready (ack_interface2user),
        .push      (tx_push),
        .pop       (tx_pop)
    );

`ifdef USER_PORT_CNT_EN
    // RX counts words accepted from the leaf, TX counts words the leaf accepted.
    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            rx_word_count <= '0;
            tx_word_count <= '0;
        end else begin
            if (rx_push) rx_word_count <= rx_word_count + 32'd1;
            if (tx_pop)  tx_word_count <= tx_word_count + 32'd1;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = rx_pop ^ tx_push;
`endif

endmodule
